// File: rtl/tt_capture_if.sv
// Hex-digit stream carrying the captured truth table, most significant nibble first.
// The producer drives valid/data and the consumer drives ready.
interface tt_capture_if;
    logic       nib_valid;
    logic       nib_ready;
    logic [3:0] nib_data;

    modport master (output nib_valid, output nib_data, input nib_ready);
    modport slave  (input nib_valid, input nib_data, output nib_ready);
endinterface

// File: rtl/tt_capture.sv
// Sweeps x over all 128 patterns, records f into a truth table, streams it out as
// 32 hex nibbles, then compares it against an expected table.
module tt_capture #(
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [6:0]         x,
    input  logic               f,
    input  logic [127:0]       exp_tt,
    output logic               busy,
    output logic [127:0]       tt,
    tt_capture_if.master       nib,
    output logic               done,
    output logic               match
);

    typedef enum logic [1:0] {IDLE, HOLD, EMIT, FIN} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state, state_nx;
    logic [6:0] idx;
    logic [3:0] cnt;
    logic [4:0] k;

    logic sample_now;
    logic last_pat;
    logic handshake;

    assign sample_now = (state == HOLD) && (cnt == SETTLE_C);
    assign last_pat   = (idx == 7'd127);
    assign handshake  = nib.nib_valid && nib.nib_ready;

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous
    // and checked first so it overrides start and every transition.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: next state defaults to the current state before the case, so no path
    // through this block leaves state_nx unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start)                  state_nx = HOLD;
            HOLD: if (sample_now && last_pat) state_nx = EMIT;
            EMIT: if (handshake && k == 5'd31) state_nx = FIN;
            FIN:                              state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            cnt   <= '0;
            k     <= '0;
            tt    <= '0;
            match <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    cnt   <= '0;
                    k     <= '0;
                    tt    <= '0;
                    match <= 1'b0;
                end
                HOLD: if (sample_now) begin
                    tt[idx] <= f;
                    cnt     <= '0;
                    if (!last_pat) idx <= idx + 7'd1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                EMIT: if (handshake && k != 5'd31) k <= k + 5'd1;
                FIN:  match <= (tt == exp_tt);
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign x    = (state == HOLD) ? idx : 7'd0;

    // {~k, 2'b11} equals 127 - 4k, the top bit of nibble k counted from the MSB end.
    assign nib.nib_valid = (state == EMIT);
    assign nib.nib_data  = (state == EMIT) ? tt[{~k, 2'b11} -: 4] : 4'd0;

endmodule

// File: tb/tb_tt_capture.sv
// Directed bench for tt_capture: a table of capture runs plus hand-written
// sequences for reset-abort, start-while-busy and ready stalls.
module tb_tt_capture;

    localparam int SETTLE = 1;
    localparam int PAT    = SETTLE + 1;
    localparam int LAT    = 128 * PAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [6:0]   x;
    logic         f;
    logic [127:0] exp_tt;
    logic         busy;
    logic [127:0] tt;
    logic         done;
    logic         match;
    int           mode;

    tt_capture_if nib_if();

    tt_capture #(.SETTLE(SETTLE)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x      (x),
        .f      (f),
        .exp_tt (exp_tt),
        .busy   (busy),
        .tt     (tt),
        .nib    (nib_if),
        .done   (done),
        .match  (match)
    );

    always #5 clk = ~clk;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Functions under test, selected by mode.
    function automatic logic fut(input int m, input logic [6:0] v);
        case (m)
            0:       return v[0];
            1:       return maj(v[0], v[1], v[2]);
            2:       return maj(v[0], maj(v[3], v[4], maj(v[2], v[3], v[6])), v[1]);
            default: return 1'b1;
        endcase
    endfunction

    assign f = fut(mode, x);

    typedef struct {
        int           mode;
        logic [127:0] exp_tt;
        logic [127:0] want_tt;
        logic         want_match;
        bit           gaps;
        bit           pokes;
    } vec_t;

    vec_t vecs[4];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_x"},         128'(x),                0);
        check({tag, "_busy"},      128'(busy),             0);
        check({tag, "_tt"},        tt,                     0);
        check({tag, "_nib_valid"}, 128'(nib_if.nib_valid), 0);
        check({tag, "_nib_data"},  128'(nib_if.nib_data),  0);
        check({tag, "_done"},      128'(done),             0);
        check({tag, "_match"},     128'(match),            0);
    endtask

    task automatic run_capture(input vec_t v);
        int           cyc;
        bit           x_ok;
        bit           busy_ok;
        bit           stable_ok;
        bit           prev_stall;
        logic [3:0]   prev_data;
        logic [127:0] got;
        int           hs;
        int           stall_k3;
        logic         rdy;

        mode   = v.mode;
        exp_tt = v.exp_tt;
        @(negedge clk);
        start   = 1'b1;
        cyc     = 0;
        x_ok    = 1'b1;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (nib_if.nib_valid || cyc > LAT + 20) break;
            if (x !== 7'((cyc - 1) / PAT)) x_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (v.pokes && cyc == 50) start = 1'b1;
        end
        check("latency",   128'(cyc),     128'(LAT));
        check("x_sweep",   128'(x_ok),    1);
        check("busy_hold", 128'(busy_ok), 1);

        got        = '0;
        hs         = 0;
        stall_k3   = 0;
        stable_ok  = 1'b1;
        prev_stall = 1'b0;
        prev_data  = 4'd0;
        for (int i = 0; i < 2000 && nib_if.nib_valid; i++) begin
            if (prev_stall && nib_if.nib_data !== prev_data) stable_ok = 1'b0;
            if (v.gaps && hs == 3 && stall_k3 < 5) begin
                rdy = 1'b0;
                stall_k3++;
            end else if (v.gaps) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            nib_if.nib_ready = rdy;
            if (rdy) begin
                got = {got[123:0], nib_if.nib_data};
                hs++;
            end
            prev_stall = !rdy;
            prev_data  = nib_if.nib_data;
            @(negedge clk);
        end
        nib_if.nib_ready = 1'b1;
        check("handshakes",   128'(hs),        32);
        check("nibble_seq",   got,             v.want_tt);
        check("stall_stable", 128'(stable_ok), 1);
        if (v.gaps) check("stall_k3", 128'(stall_k3), 5);

        check("fin_done",  128'(done), 1);
        check("fin_busy",  128'(busy), 1);
        check("fin_valid", 128'(nib_if.nib_valid), 0);
        if (v.pokes) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_done",  128'(done),  0);
        check("post_busy",  128'(busy),  0);
        check("post_match", 128'(match), 128'(v.want_match));
        check("post_tt",    tt,          v.want_tt);
        check("post_x",     128'(x),     0);
        @(negedge clk);
        check("idle_busy",  128'(busy),  0);
        check("idle_match", 128'(match), 128'(v.want_match));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] nested_tt;
        int           wait_cyc;

        for (int i = 0; i < 128; i++) nested_tt[i] = fut(2, 7'(i));
        vecs[0] = '{3, {128{1'b1}}, {128{1'b1}}, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{0, 128'd0,      {32{4'hA}},  1'b0, 1'b0, 1'b0};
        vecs[2] = '{1, {16{8'hE8}}, {16{8'hE8}}, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2, 128'd0,      nested_tt,   1'b0, 1'b1, 1'b0};

        // Reset held together with start: reset must win.
        rst              = 1'b1;
        start            = 1'b1;
        nib_if.nib_ready = 1'b1;
        mode             = 0;
        exp_tt           = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Abort a run at idx=60 with reset.
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (x !== 7'd60 && wait_cyc < 400) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("abort_reach_60", 128'(x), 60);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 128'(done), 0);
        check("abort_idle",    128'(busy), 0);

        for (int t = 0; t < 4; t++) run_capture(vecs[t]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
